// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
//   Result-consuming end of the ALU. ALU results land in a NREGS x WIDTH
//   register file plus a carry/overflow flags register. A secondary
//   valid/ready bus port (loader/debug) shares the file's single write port.
//   The ALU always wins that port. A bus write that collides with an ALU
//   write is parked in a one-entry pending buffer. It commits on the next
//   cycle that has no ALU write.
//
//   Optional feature macro: ALU_WB_R0_ZERO_EN
//     Defined  : register 0 is hardwired to zero. Writes to index 0 are
//                dropped, and reads of index 0 return 0 with no bypass.
//                ALU flags still update on an ALU write to index 0.
//     Undefined: register 0 is an ordinary register.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   alu_out_en/alu_out  : ALU result valid / data
//   alu_dst             : ALU destination register index
//   alu_flag_carry/_overflow : flags that come with the ALU result
//   bus_wr_valid/ready  : bus write handshake (accepted when valid && ready)
//   bus_wr_addr/data    : bus write index / data
//   rd_a_addr/rd_a_data : combinational read port A (with bypass)
//   rd_b_addr/rd_b_data : combinational read port B (with bypass)
//   flag_carry/overflow : registered flags of the last ALU writeback
//   pending             : pending buffer occupied
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | pending buffer empty, bus write accepted (bus_wr_ready=1)
// HELD  | pending buffer holds a bus write, bus stalled (ready=0)
// ---------------------------------------------------------------------------
module alu_writeback #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_out_en,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_dst,
  input  logic             alu_flag_carry,
  input  logic             alu_flag_overflow,
  input  logic             bus_wr_valid,
  output logic             bus_wr_ready,
  input  logic [3:0]       bus_wr_addr,
  input  logic [WIDTH-1:0] bus_wr_data,
  input  logic [3:0]       rd_a_addr,
  output logic [WIDTH-1:0] rd_a_data,
  input  logic [3:0]       rd_b_addr,
  output logic [WIDTH-1:0] rd_b_data,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             pending
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] regs [NREGS];
  logic [3:0]       p_addr;
  logic [WIDTH-1:0] p_data;

  logic             bus_accept;
  logic             capture;
  logic             wr_en_raw;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  // bus_wr_ready comes from state alone, so the accept term never loops
  // back through the ready output.
  assign bus_accept = bus_wr_valid && (state == IDLE);
  assign capture    = bus_accept && alu_out_en;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = HELD;
      HELD: if (!alu_out_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    bus_wr_ready = 1'b0;
    pending      = 1'b0;
    case (state)
      IDLE: bus_wr_ready = 1'b1;
      HELD: pending      = 1'b1;
      default: bus_wr_ready = 1'b0;
    endcase
  end

  // ---------------- write-port arbitration ----------------
  // At most one writer per cycle: ALU, then the held write, then the bus.
  always_comb begin
    wr_en_raw = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    if (alu_out_en) begin
      wr_en_raw = 1'b1;
      wr_addr   = alu_dst;
      wr_data   = alu_out;
    end else if (state == HELD) begin
      wr_en_raw = 1'b1;
      wr_addr   = p_addr;
      wr_data   = p_data;
    end else if (bus_accept) begin
      wr_en_raw = 1'b1;
      wr_addr   = bus_wr_addr;
      wr_data   = bus_wr_data;
    end
  end

`ifdef ALU_WB_R0_ZERO_EN
  assign wr_en = wr_en_raw && (wr_addr != 4'd0);
`else
  assign wr_en = wr_en_raw;
`endif

  // ---------------- register file, flags, pending buffer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      p_addr        <= '0;
      p_data        <= '0;
    end else begin
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end
      if (alu_out_en) begin
        flag_carry    <= alu_flag_carry;
        flag_overflow <= alu_flag_overflow;
      end
      if (capture) begin
        p_addr <= bus_wr_addr;
        p_data <= bus_wr_data;
      end
    end
  end

  // ---------------- read ports ----------------
  // Bypass order: this cycle's ALU result, then the held bus write, then
  // the array. A bus write that has not been accepted yet is never visible.
  always_comb begin
    rd_a_data = regs[rd_a_addr];
    if ((state == HELD) && (p_addr == rd_a_addr)) rd_a_data = p_data;
    if (alu_out_en && (alu_dst == rd_a_addr))     rd_a_data = alu_out;
`ifdef ALU_WB_R0_ZERO_EN
    if (rd_a_addr == 4'd0) rd_a_data = '0;
`endif
  end

  always_comb begin
    rd_b_data = regs[rd_b_addr];
    if ((state == HELD) && (p_addr == rd_b_addr)) rd_b_data = p_data;
    if (alu_out_en && (alu_dst == rd_b_addr))     rd_b_data = alu_out;
`ifdef ALU_WB_R0_ZERO_EN
    if (rd_b_addr == 4'd0) rd_b_data = '0;
`endif
  end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_out_en;
  logic [15:0] alu_out;
  logic [3:0]  alu_dst;
  logic        alu_flag_carry;
  logic        alu_flag_overflow;
  logic        bus_wr_valid;
  logic        bus_wr_ready;
  logic [3:0]  bus_wr_addr;
  logic [15:0] bus_wr_data;
  logic [3:0]  rd_a_addr;
  logic [15:0] rd_a_data;
  logic [3:0]  rd_b_addr;
  logic [15:0] rd_b_data;
  logic        flag_carry;
  logic        flag_overflow;
  logic        pending;

  always #5 clk = ~clk;

  alu_writeback #(.NREGS(16), .WIDTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .alu_out_en        (alu_out_en),
    .alu_out           (alu_out),
    .alu_dst           (alu_dst),
    .alu_flag_carry    (alu_flag_carry),
    .alu_flag_overflow (alu_flag_overflow),
    .bus_wr_valid      (bus_wr_valid),
    .bus_wr_ready      (bus_wr_ready),
    .bus_wr_addr       (bus_wr_addr),
    .bus_wr_data       (bus_wr_data),
    .rd_a_addr         (rd_a_addr),
    .rd_a_data         (rd_a_data),
    .rd_b_addr         (rd_b_addr),
    .rd_b_data         (rd_b_data),
    .flag_carry        (flag_carry),
    .flag_overflow     (flag_overflow),
    .pending           (pending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents, flags, and a queue
  // of accepted bus writes that have not landed yet (at most one).
  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } pw_t;

  logic [15:0] m_regs [16];
  logic        m_c, m_o;
  pw_t         pq [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
`ifdef ALU_WB_R0_ZERO_EN
    if (a == 4'd0) return 16'h0000;
`endif
    if (alu_out_en && alu_dst == a) return alu_out;
    if (pq.size() > 0 && pq[0].a == a) return pq[0].d;
    return m_regs[a];
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [15:0] d);
`ifdef ALU_WB_R0_ZERO_EN
    if (a == 4'd0) return;
`endif
    m_regs[a] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_c = 1'b0;
    m_o = 1'b0;
    pq.delete();
  endtask

  task automatic m_edge();
    bit   ready;
    bit   accept;
    pw_t  e;
    ready  = (pq.size() == 0);
    accept = bus_wr_valid && ready;
    if (rst) begin
      m_reset();
    end else if (alu_out_en) begin
      m_write(alu_dst, alu_out);
      m_c = alu_flag_carry;
      m_o = alu_flag_overflow;
      if (accept) begin
        e.a = bus_wr_addr;
        e.d = bus_wr_data;
        pq.push_back(e);
      end
    end else if (pq.size() > 0) begin
      e = pq.pop_front();
      m_write(e.a, e.d);
    end else if (accept) begin
      m_write(bus_wr_addr, bus_wr_data);
    end
  endtask

  task automatic drive(input logic ae, input logic [15:0] ao, input logic [3:0] ad,
                       input logic c, input logic o,
                       input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                       input logic [3:0] ra, input logic [3:0] rb);
    alu_out_en        = ae;
    alu_out           = ao;
    alu_dst           = ad;
    alu_flag_carry    = c;
    alu_flag_overflow = o;
    bus_wr_valid      = bv;
    bus_wr_addr       = ba;
    bus_wr_data       = bd;
    rd_a_addr         = ra;
    rd_b_addr         = rb;
  endtask

  task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, ra, rb);
  endtask

  // Compare every observable against the model, then clock one edge.
  task automatic cycle();
    #2;
    check("rd_a", rd_a_data, m_read(rd_a_addr));
    check("rd_b", rd_b_data, m_read(rd_b_addr));
    check("ready_pending", {14'b0, bus_wr_ready, pending},
          {14'b0, pq.size() == 0, pq.size() != 0});
    check("flags", {14'b0, flag_carry, flag_overflow}, {14'b0, m_c, m_o});
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle(4'h0, 4'h0);
    repeat (2) @(posedge clk);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset clears a bus-written register
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd3);
    cycle();
    idle(4'd3, 4'd3);
    #1 check("pre_rst_reg3", rd_a_data, 16'h1234);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    idle(4'd3, 4'd0);
    #1 check("rst_reg3", rd_a_data, 16'h0000);
    check("rst_ctl", {13'b0, flag_carry, flag_overflow, bus_wr_ready}, 16'h0001);
    check("rst_pending", {15'b0, pending}, 16'h0000);
    cycle();

    // ALU writeback with same-cycle bypass
    drive(1'b1, 16'hBEEF, 4'd5, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 4'd0, 4'd5);
    #1 check("alu_bypass", rd_b_data, 16'hBEEF);
    cycle();
    idle(4'd5, 4'd0);
    #1 check("alu_reg5", rd_a_data, 16'hBEEF);
    check("alu_flags", {14'b0, flag_carry, flag_overflow}, 16'h0002);
    cycle();

    // Collision: ALU wins, bus write parked and visible through bypass
    drive(1'b1, 16'h0001, 4'd2, 1'b0, 1'b0, 1'b1, 4'd7, 16'hAAAA, 4'd7, 4'd2);
    #1 check("coll_unaccepted", rd_a_data, 16'h0000);
    cycle();
    idle(4'd7, 4'd2);
    #1 check("coll_held", {14'b0, pending, bus_wr_ready}, 16'h0002);
    check("coll_pbypass", rd_a_data, 16'hAAAA);
    check("coll_reg2", rd_b_data, 16'h0001);
    cycle();
    idle(4'd7, 4'd2);
    #1 check("coll_drain", rd_a_data, 16'hAAAA);
    check("coll_idle", {15'b0, pending}, 16'h0000);
    cycle();

    // Starvation: pending write waits behind three ALU writes, then lands
    drive(1'b1, 16'h0099, 4'd1, 1'b0, 1'b0, 1'b1, 4'd4, 16'h5555, 4'd4, 4'd1);
    cycle();
    drive(1'b1, 16'h0010, 4'd4, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 4'd4, 4'd1);
    cycle();
    drive(1'b1, 16'h0020, 4'd4, 1'b1, 1'b0, 1'b1, 4'd8, 16'hDEAD, 4'd4, 4'd8);
    cycle();
    drive(1'b1, 16'h0030, 4'd4, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 4'd4, 4'd1);
    #1 check("starve_alu_bypass", rd_a_data, 16'h0030);
    check("starve_held", {15'b0, pending}, 16'h0001);
    cycle();
    idle(4'd4, 4'd8);
    #1 check("starve_pbypass", rd_a_data, 16'h5555);
    check("starve_flags", {14'b0, flag_carry, flag_overflow}, 16'h0001);
    cycle();
    idle(4'd4, 4'd8);
    #1 check("starve_reg4", rd_a_data, 16'h5555);
    check("starve_nobus8", rd_b_data, 16'h0000);
    cycle();

    // Reset while HELD discards the parked write
    drive(1'b1, 16'h0002, 4'd1, 1'b0, 1'b0, 1'b1, 4'd9, 16'h7777, 4'd9, 4'd1);
    cycle();
    idle(4'd9, 4'd1);
    rst = 1'b1;
    #1 check("rsth_pending", {15'b0, pending}, 16'h0001);
    cycle();
    rst = 1'b0;
    idle(4'd9, 4'd1);
    #1 check("rsth_reg9", rd_a_data, 16'h0000);
    check("rsth_ctl", {14'b0, pending, bus_wr_ready}, 16'h0001);
    cycle();

`ifdef ALU_WB_R0_ZERO_EN
    drive(1'b1, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 4'd0, 4'd0);
    #1 check("r0_alu_read", rd_a_data, 16'h0000);
    cycle();
    idle(4'd0, 4'd0);
    #1 check("r0_flag_ov", {15'b0, flag_overflow}, 16'h0001);
    check("r0_after_alu", rd_a_data, 16'h0000);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h1111, 4'd0, 4'd0);
    #1 check("r0_bus_ready", {15'b0, bus_wr_ready}, 16'h0001);
    cycle();
    idle(4'd0, 4'd0);
    #1 check("r0_after_bus", rd_b_data, 16'h0000);
    cycle();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] d, b, ra, rb;
      d  = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? d : 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 1) == 1) ? d : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 1) == 1) ? b : 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 2) != 0), 16'($urandom), d,
            1'($urandom), 1'($urandom),
            1'($urandom), b, 16'($urandom), ra, rb);
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Result-consuming end of the ALU interface: captures `out_en`/`out`/`o_dst`/`flag_carry`/`flag_overflow` into a 16 x 16-bit register file and a flags register.
- Provides two combinational read ports that drive the ALU `a`/`b` operands.
- A secondary valid/ready bus write port (loader/debug) shares the file. Conflicts are resolved by a one-entry pending buffer, ALU priority.

Parameters:
- NREGS, 16, number of registers; the address width is fixed at 4 bits.
- WIDTH, 16, data width of registers, ALU result and bus data.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_out_en  input  1  ALU result valid this cycle.
- alu_out  input  16  ALU result.
- alu_dst  input  4  destination register of the ALU result.
- alu_flag_carry  input  1  ALU carry for this result.
- alu_flag_overflow  input  1  ALU overflow for this result.
- bus_wr_valid  input  1  bus write request.
- bus_wr_ready  output  1  bus write accepted when valid && ready.
- bus_wr_addr  input  4  bus write register index.
- bus_wr_data  input  16  bus write data.
- rd_a_addr  input  4  read port A index.
- rd_a_data  output  16  read port A data, combinational.
- rd_b_addr  input  4  read port B index.
- rd_b_data  output  16  read port B data, combinational.
- flag_carry  output  1  registered carry of the last ALU writeback.
- flag_overflow  output  1  registered overflow of the last ALU writeback.
- pending  output  1  pending buffer occupied (state == HELD).

Behaviour:
- Reset (rst=1 at edge):
  - All registers become 0.
  - flag_carry=0, flag_overflow=0.
  - Pending buffer is cleared (any held write is discarded) and the FSM goes to IDLE.
  - bus_wr_ready=1 in the cycle after reset.
  - Reset mid-HELD drops the held write silently.
- FSM states:
  - IDLE: pending empty, bus_wr_ready=1.
  - HELD: pending full, bus_wr_ready=0.
- Per-edge priority, evaluated in this order:
  1. alu_out_en=1: reg[alu_dst] <= alu_out; flag_carry/flag_overflow <= ALU flags.
  2. Else if HELD: reg[p_addr] <= p_data; go to IDLE.
  3. Else if IDLE and bus accept: reg[bus_wr_addr] <= bus_wr_data.
- IDLE with bus accept and alu_out_en=1 in the same cycle:
  - ALU write commits.
  - Bus write is captured into the pending buffer (p_addr, p_data); go to HELD.
  - This applies even when the addresses match: the held bus write lands later and overwrites the ALU result.
- HELD with alu_out_en=1: remain HELD; the ALU write commits; the pending write waits.
- Flags change only on ALU writeback. Bus and pending writes never touch the flags.
- Read ports: purely combinational, zero latency, with bypass priority (highest first):
  1. Current-cycle ALU write (alu_out_en && alu_dst==addr) -> alu_out.
  2. Pending entry (HELD && p_addr==addr) -> p_data.
  3. Array contents.
- Bus writes are never bypassed before acceptance.
- Throughput:
  - One ALU writeback per cycle, indefinitely.
  - Under sustained alu_out_en=1 a held bus write can starve. This is accepted: the ALU has absolute priority.
- bus_wr_ready depends only on state, never combinationally on bus_wr_valid.

Optional Feature:
- Macro: ALU_WB_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to zero; writes to index 0 from the ALU, pending buffer or bus are discarded.
  - Reads of index 0 return 0, with no bypass.
  - A bus write to index 0 is still accepted (handshake completes) but has no effect. If it collides with an ALU write, it still enters HELD for one commit cycle, for uniform timing.
  - ALU flags still update on an ALU write to index 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset: write reg3=0x1234 via bus, assert rst one cycle -> rd_a(3)=0x0000, flags=0, bus_wr_ready=1, pending=0.
- ALU writeback and bypass: alu_out_en=1, alu_dst=5, alu_out=0xBEEF, carry=1 -> same cycle rd_b(5)=0xBEEF; after edge reg5=0xBEEF, flag_carry=1, flag_overflow=0.
- Collision to HELD: cycle0 ALU dst=2 data 0x0001 plus bus addr=7 data 0xAAAA -> pending=1, bus_wr_ready=0, rd_a(7)=0xAAAA via bypass. Cycle1 alu_out_en=0 -> reg7=0xAAAA, pending=0.
- Starvation then drain: HELD with bus addr=4 data 0x5555; 3 consecutive ALU writes to dst=4 (0x0010, 0x0020, 0x0030) -> remain HELD. First idle edge -> reg4=0x5555, flags hold the third ALU write's values.
- Reset mid-HELD: in HELD (addr 9, data 0x7777), assert rst -> reg9=0, pending=0, bus_wr_ready=1.
- With ALU_WB_R0_ZERO_EN: ALU dst=0 data 0xFFFF with overflow=1 -> rd_a(0)=0x0000, flag_overflow=1. Bus write addr0 data 0x1111 completes handshake -> rd(0)=0x0000.
